// File: rtl/input_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// input_ctrl_pkg
//
// Purpose:
//   Constants and types shared by the memory-mapped input peripheral. It holds
//   the read-select codes seen by the load path, the switch and button counts,
//   and a helper that zero-extends a button vector onto the 32-bit read bus.
//
// Contents:
//   NUM_BTN    - number of push-buttons
//   SW_W       - number of slide switches (also the read bus width)
//   sel_e      - read-select encoding (switches, button levels, button events)
//   btn_to_bus - zero-extends a NUM_BTN-wide vector to SW_W bits
// -----------------------------------------------------------------------------
package input_ctrl_pkg;

    localparam int NUM_BTN = 4;
    localparam int SW_W    = 32;

    // Code 3 is reserved and always reads as zero.
    typedef enum logic [1:0] {
        SEL_SW  = 2'd0,
        SEL_BTN = 2'd1,
        SEL_EVT = 2'd2,
        SEL_RSV = 2'd3
    } sel_e;

    // Button-derived read values occupy the low bits of the bus.
    function automatic logic [SW_W-1:0] btn_to_bus(input logic [NUM_BTN-1:0] v);
        logic [SW_W-1:0] bus;
        bus              = '0;
        bus[NUM_BTN-1:0] = v;
        return bus;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Purpose:
//   Debounces one push-button. The raw pin is optionally inverted so that a
//   logical 1 always means "pressed". It then passes through a two-flop
//   synchroniser. The debounced level only changes once the synchronised
//   sample has disagreed with it for DEBOUNCE_CYCLES consecutive clocks. Any
//   return to the current level restarts the count.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive disagreeing samples needed to change level (>= 1)
//   ACTIVE_LOW      - 1: pin reads 0 when pressed, so it is inverted on entry
//
// Ports:
//   i_clk    - system clock
//   i_rst    - synchronous active-high reset
//   i_raw    - raw button pin, asynchronous to i_clk
//   o_stable - debounced, registered button level (1 = pressed)
//   o_rise   - high during the cycle whose closing edge takes o_stable 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_lvl;
    logic             sync_meta;
    logic             samp;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Normalise polarity before synchronising. The synchroniser then resets
    // to "released", which matches the reset value of the debounced level,
    // so idle keys cannot produce a spurious event after reset.
    assign pin_lvl = ACTIVE_LOW ? ~i_raw : i_raw;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_meta <= 1'b0;
            samp      <= 1'b0;
        end else begin
            sync_meta <= pin_lvl;
            samp      <= sync_meta;
        end
    end

    // The level flips on the edge where the disagreement has lasted the full
    // window. That edge is the one that would otherwise advance the counter
    // past CNT_LAST.
    assign flip = (samp != stable) && (cnt == CNT_LAST);

    // Debounce counter and stable level. The counter only runs while the
    // sample disagrees with the stable level. Agreement, including a bounce
    // back, clears it. Reset discards any partial count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (samp == stable) begin
            cnt    <= '0;
        end else if (flip) begin
            stable <= samp;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // The rise is combinational so the parent can set the event bit on the
    // same edge that the stable level goes high.
    assign o_stable = stable;
    assign o_rise   = flip & samp;

endmodule

// File: rtl/input_ctrl.sv
// -----------------------------------------------------------------------------
// input_ctrl
//
// Purpose:
//   Controller for the memory-mapped input peripheral, which has 32 slide
//   switches and 4 push-buttons.
//   - Switches are synchronised but not debounced.
//   - Each button is debounced by its own btn_debounce instance.
//   - Button presses (debounced 0->1) set sticky pending bits.
//   - A clearing read of the event register drops those bits.
//   Read data is a pure combinational mux of registered state, so the load
//   path sees it in the same cycle with no wait states.
//
// Configuration:
//   INPUT_CTRL_IRQ_EN - when defined, adds the o_irq output, a registered
//                       "any event pending" flag.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable samples needed before a button level changes (>= 1)
//   BTN_ACTIVE_LOW  - 1: button pins are inverted so that logical 1 = pressed
//
// Ports:
//   i_clk    - system clock
//   i_rst    - synchronous active-high reset
//   i_io_sw  - raw switch pins (asynchronous)
//   i_io_btn - raw button pins (asynchronous)
//   i_sel    - read select: 0 switches, 1 button levels, 2 events, 3 reserved
//   i_rd_en  - load strobe; a strobed read of select 2 clears the events
//   o_rdata  - read data
//   o_irq    - pending-event interrupt (INPUT_CTRL_IRQ_EN only)
// -----------------------------------------------------------------------------
module input_ctrl
    import input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SW_W-1:0]    i_io_sw,
    input  logic [NUM_BTN-1:0] i_io_btn,
    input  logic [1:0]         i_sel,
    input  logic               i_rd_en,
    output logic [SW_W-1:0]    o_rdata
`ifdef INPUT_CTRL_IRQ_EN
    ,
    output logic               o_irq
`endif
);

    logic [SW_W-1:0]    sw_meta;
    logic [SW_W-1:0]    sw_sync;
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] pend_clr;
    logic [NUM_BTN-1:0] pend_next;

    // Switch synchroniser. The switches are level inputs read by software,
    // so two flops are enough and no debounce is applied.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= i_io_sw;
            sw_sync <= sw_meta;
        end
    end

    // One debouncer per button.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW)
        ) u_debounce (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_io_btn[g]),
            .o_stable (btn_stable[g]),
            .o_rise   (btn_rise[g])
        );
    end

    // Pending events. The clear is applied before the new rises are OR-ed in.
    // A press landing on the same edge as a clearing read therefore survives
    // and is not lost. Releases never reach this register.
    assign pend_clr  = {NUM_BTN{i_rd_en && (i_sel == SEL_EVT)}};
    assign pend_next = (pend & ~pend_clr) | btn_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

`ifdef INPUT_CTRL_IRQ_EN
    // The interrupt is registered from pend_next rather than pend, so it
    // rises and falls on the same edge as the pending bits themselves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= |pend_next;
        end
    end
`endif

    // Read mux. Every source is a flop, so the output is glitch-free apart
    // from select changes. The event read shows the value before the clear.
    always_comb begin
        o_rdata = '0;
        case (sel_e'(i_sel))
            SEL_SW:  o_rdata = sw_sync;
            SEL_BTN: o_rdata = btn_to_bus(btn_stable);
            SEL_EVT: o_rdata = btn_to_bus(pend);
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_input_ctrl
//
// Self-checking bench for input_ctrl with DEBOUNCE_CYCLES=4 and active-low
// buttons. It runs in four phases:
//   1. A vector table covering reset and switch pass-through.
//   2. Hand-written sequences for press, bounce, clear-on-read, simultaneous
//      set/clear, release and mid-debounce reset.
//   3. A randomized phase.
//   4. A summary line.
// Every clock edge is also compared against a behavioural model. The model
// treats each button as a delay line plus a "last N samples all disagree"
// window. Define INPUT_CTRL_IRQ_EN to also cover o_irq.
// -----------------------------------------------------------------------------
module tb_input_ctrl;
    import input_ctrl_pkg::*;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [1:0]  sel;
    logic        rd_en;
    logic [31:0] rdata;
`ifdef INPUT_CTRL_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_io_sw  (sw),
        .i_io_btn (btn),
        .i_sel    (sel),
        .i_rd_en  (rd_en),
        .o_rdata  (rdata)
`ifdef INPUT_CTRL_IRQ_EN
        ,
        .o_irq    (irq)
`endif
    );

    // 10 ns clock; inputs change on the falling edge, outputs are sampled there.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference state
    logic [31:0] m_sw1, m_sw2;
    bit   [3:0]  m_s1, m_s2, m_stable, m_pend;
    bit          m_irq;
    bit          m_hist[4][$];

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        bit [3:0] nst;
        bit [3:0] rise;
        bit       all_differ;
        if (rst) begin
            m_sw1 = '0; m_sw2 = '0; m_s1 = '0; m_s2 = '0;
            m_stable = '0; m_pend = '0; m_irq = 1'b0;
            for (int b = 0; b < 4; b++) m_hist[b].delete();
        end else begin
            nst = m_stable;
            for (int b = 0; b < 4; b++) begin
                m_hist[b].push_back(m_s2[b]);
                if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
                if (m_hist[b].size() == DEB) begin
                    all_differ = 1'b1;
                    foreach (m_hist[b][i]) if (m_hist[b][i] == m_stable[b]) all_differ = 1'b0;
                    if (all_differ) nst[b] = ~m_stable[b];
                end
            end
            rise = nst & ~m_stable;
            if (rd_en && sel == 2'd2) m_pend = rise;
            else                      m_pend = m_pend | rise;
            m_irq    = (m_pend != 4'd0);
            m_stable = nst;
            m_s2     = m_s1;
            m_s1     = ~btn;
            m_sw2    = m_sw1;
            m_sw1    = sw;
        end
    endtask

    function automatic logic [31:0] modelRead();
        case (sel)
            2'd0:    return m_sw2;
            2'd1:    return {28'd0, m_stable};
            2'd2:    return {28'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic applyStimulus(input logic r, input logic [31:0] s, input logic [3:0] b,
                                 input logic [1:0] sl, input logic re);
        rst = r; sw = s; btn = b; sel = sl; rd_en = re;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_rdata", rdata, modelRead());
`ifdef INPUT_CTRL_IRQ_EN
        checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    // One clock edge: the model follows the edge, then outputs are checked
    // at the falling edge.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkModel();
    endtask

    // Check the combinational read after an input change, away from any edge.
    task automatic checkNow(input string name, input logic [31:0] exp);
        #1;
        checkOutput(name, rdata, exp);
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [1:0]  sel;
        logic        rd_en;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Reset and switch-path vectors: one edge per row, then compare.
        vecs[0]  = '{1'b1, 32'hA5A5_0F0F, 4'hF, 2'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'hA5A5_0F0F, 4'hF, 2'd1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'hA5A5_0F0F, 4'hF, 2'd2, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'hA5A5_0F0F, 4'hF, 2'd0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'hA5A5_0F0F, 4'hF, 2'd0, 1'b0, 32'hA5A5_0F0F};
        vecs[5]  = '{1'b0, 32'hA5A5_0F0F, 4'hF, 2'd1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'hA5A5_0F0F, 4'hF, 2'd2, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h1234_5678, 4'hF, 2'd0, 1'b0, 32'hA5A5_0F0F};
        vecs[8]  = '{1'b0, 32'h1234_5678, 4'hF, 2'd0, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b0, 32'h1234_5678, 4'hF, 2'd3, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h1234_5678, 4'hF, 2'd1, 1'b0, 32'h0};

        applyStimulus(1'b1, 32'hA5A5_0F0F, 4'hF, 2'd0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sw, vecs[i].btn, vecs[i].sel, vecs[i].rd_en);
            tick();
            checkOutput($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // Clean press of btn[2]: the level appears only after edge k+5.
        applyStimulus(1'b0, 32'h1234_5678, 4'hB, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("press_lvl%0d", i), rdata, (i == 5) ? 32'h4 : 32'h0);
`ifdef INPUT_CTRL_IRQ_EN
            checkOutput($sformatf("press_irq%0d", i), {31'd0, irq}, (i == 5) ? 32'h1 : 32'h0);
`endif
        end

        // A non-strobed event read has no side effect.
        applyStimulus(1'b0, 32'h1234_5678, 4'hB, 2'd2, 1'b0);
        tick();
        checkOutput("evt_noclr0", rdata, 32'h4);
        tick();
        checkOutput("evt_noclr1", rdata, 32'h4);

        // A clearing read shows the pre-clear value, then reads zero.
        applyStimulus(1'b0, 32'h1234_5678, 4'hB, 2'd2, 1'b1);
        checkNow("clr_pre", 32'h4);
        tick();
`ifdef INPUT_CTRL_IRQ_EN
        checkOutput("clr_irq", {31'd0, irq}, 32'h0);
`endif
        applyStimulus(1'b0, 32'h1234_5678, 4'hB, 2'd2, 1'b0);
        checkNow("clr_post", 32'h0);

        // Releasing the button drops the level after 5 edges; no event is set.
        applyStimulus(1'b0, 32'h1234_5678, 4'hF, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("release_lvl%0d", i), rdata, (i == 5) ? 32'h0 : 32'h4);
        end
        applyStimulus(1'b0, 32'h1234_5678, 4'hF, 2'd2, 1'b0);
        checkNow("release_evt", 32'h0);

        // Bounce: btn[0] low/high every 2 cycles never debounces.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h1234_5678, ((i / 2) % 2 == 0) ? 4'hE : 4'hF, 2'd1, 1'b0);
            tick();
            checkOutput("bounce_lvl", rdata, 32'h0);
        end
        applyStimulus(1'b0, 32'h1234_5678, 4'hF, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("bounce_lvl_end", rdata, 32'h0);
        applyStimulus(1'b0, 32'h1234_5678, 4'hF, 2'd2, 1'b0);
        checkNow("bounce_evt", 32'h0);

        // Simultaneous set and clear: press btn[0] so pend = 1. Then the
        // btn[1] rise is placed on the edge of a clearing read.
        applyStimulus(1'b0, 32'h1234_5678, 4'hE, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sim_pend1", rdata, 32'h1);
        applyStimulus(1'b0, 32'h1234_5678, 4'hC, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("sim_before", rdata, 32'h1);
        applyStimulus(1'b0, 32'h1234_5678, 4'hC, 2'd2, 1'b1);
        checkNow("sim_read", 32'h1);
        tick();
        applyStimulus(1'b0, 32'h1234_5678, 4'hC, 2'd2, 1'b0);
        checkNow("sim_after", 32'h2);
        applyStimulus(1'b0, 32'h1234_5678, 4'hC, 2'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h1234_5678, 4'hC, 2'd2, 1'b0);
        checkNow("sim_cleared", 32'h0);

        // Mid-debounce reset: btn[3] counts to 2, then reset discards it and
        // a full fresh window is needed after release.
        applyStimulus(1'b0, 32'h1234_5678, 4'hF, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("mid_idle", rdata, 32'h0);
        applyStimulus(1'b0, 32'h1234_5678, 4'h7, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(1'b1, 32'h1234_5678, 4'h7, 2'd1, 1'b0);
        tick();
        checkOutput("mid_rst", rdata, 32'h0);
        applyStimulus(1'b0, 32'h1234_5678, 4'h7, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("mid_lvl%0d", i), rdata, (i == 5) ? 32'h8 : 32'h0);
        end

        // Randomized phase, checked against the model on every edge.
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  nb;
            logic [31:0] ns;
            nb = btn;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) nb[b] = ~nb[b];
            ns = ($urandom_range(0, 3) == 0) ? $urandom : sw;
            applyStimulus(($urandom_range(0, 79) == 0), ns, nb,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_ctrl.md
# input_ctrl

Controller for the memory-mapped input peripheral (32 slide switches, 4 push-buttons). It synchronises switches, debounces each button, and latches button press events into sticky pending bits. It serves registered, glitch-free values to the load path through a combinational read port, and clears events on read. It sits between the board pins and the load-store unit's input-region mux.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable sync samples required before a button's debounced level changes; legal range ≥ 1.
- BTN_ACTIVE_LOW, 1, 1 means raw button pins are inverted before synchronisation, so logical 1 = pressed.

Ports:
- i_clk  in  1  system clock. The block uses this single clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_io_sw  in  32  raw switch pins, asynchronous to i_clk.
- i_io_btn  in  4  raw button pins, asynchronous to i_clk.
- i_sel  in  2  read select: 0 = switches, 1 = debounced button levels, 2 = button events, 3 = reserved.
- i_rd_en  in  1  load strobe; qualifies clear-on-read.
- o_rdata  out  32  read data; combinational from registered state.
- o_irq  out  1  only with the configuration macro; see Configuration.

## Operation

- **Switches.** Two-flop synchroniser per bit, with no debounce. The sel 0 read returns the second flop stage.
- **Buttons, per bit b.**
  - Pin is optionally inverted, then passes through a two-flop synchroniser to produce samp[b].
  - Debounce counter cnt[b] has width $clog2(DEBOUNCE_CYCLES+1).
  - If samp == stable: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable ← samp and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any bounce back to the stable level restarts the count from 0.
- **Events.** rise[b] = (stable changes 0→1 this edge). Pending update: pend ← (pend & ~clr) | rise.
  - clr = {4{i_rd_en && i_sel==2}}.
  - A rise on the same edge as a clearing read leaves that bit set; the event is not lost.
  - Releases (1→0) never set pending.
- **Read data.**
  - sel 0: sw_sync.
  - sel 1: {28'b0, stable}.
  - sel 2: {28'b0, pend}. The value shown is the pre-clear value in the read cycle.
  - sel 3: 32'b0.
- **Reads without clear.** Reads with i_rd_en=0, or reads of sel ≠ 2, have no side effect.
- **Reset.** All synchroniser flops, stable, cnt, pend and o_irq reset to 0.
  - With BTN_ACTIVE_LOW=1 and keys released, the first post-reset samples equal stable, so no spurious event occurs.
  - Reset asserted mid-debounce discards the partial count.

## Timing

- **Switches.** A raw change sampled at edge k appears on o_rdata (sel 0) after edge k+1: two-cycle latency.
- **Buttons.** A raw change sampled at edge k gives samp changed after edge k+1. stable changes at edge k+1+DEBOUNCE_CYCLES, provided samp holds. The pend bit sets on that same edge.
- **Clearing read.** Clear takes effect at the edge ending the read cycle. A sel 2 read in the next cycle returns 0 unless a new rise occurred.
- **Read data.** o_rdata is valid in the same cycle as i_sel, with no wait states. This is compatible with the single-cycle datapath.

## Configuration

- **INPUT_CTRL_IRQ_EN defined:**
  - o_irq port is present.
  - o_irq is a registered |pend_next, so it asserts on the edge pend becomes non-zero.
  - o_irq deasserts on the edge a clearing read empties pend.
  - o_irq resets to 0.
- **INPUT_CTRL_IRQ_EN undefined:** the o_irq port and its register are absent. All other behaviour is identical.

## Structure

- **Package input_ctrl_pkg:**
  - select codes SEL_SW=2'd0, SEL_BTN=2'd1, SEL_EVT=2'd2.
  - constants NUM_BTN=4 and SW_W=32.
- **Sub-module btn_debounce, one instance per button:**
  - Contents: synchroniser, counter, stable flop and rise output.
  - Parameters DEBOUNCE_CYCLES and ACTIVE_LOW.
  - Ports: i_clk, i_rst, i_raw, o_stable, o_rise.
- **Top level:** instantiates btn_debounce ×NUM_BTN and contains the switch synchroniser, pend register, read mux and optional IRQ flop.

## Test plan

1. **Reset.** Hold i_rst 3 cycles with i_io_btn=4'hF (released) and i_io_sw=32'hA5A5_0F0F. Required response:
   - During reset, all reads return 0.
   - 2 cycles after release, sel 0 reads 32'hA5A5_0F0F.
   - sel 1 and sel 2 read 0.
2. **Clean press, DEBOUNCE_CYCLES=4.** Drive btn[2] low at edge k and hold. Required response:
   - sel 1 reads 32'h4 starting after edge k+5, not before.
   - sel 2 reads 32'h4.
   - With INPUT_CTRL_IRQ_EN, o_irq=1 from the same edge.
3. **Bounce.** Toggle btn[0] low/high every 2 cycles for 20 cycles, then hold high. Required response: stable stays 0 and pend stays 0.
4. **Clear-on-read.** With pend=4'h4, do a sel 2 read with i_rd_en=1. Required response:
   - That cycle reads 32'h4.
   - The next cycle reads 0.
   - o_irq drops on the same edge.
   - A sel 2 read with i_rd_en=0 leaves pend unchanged.
5. **Simultaneous set and clear.** Time a btn[1] debounced rise to the exact edge of a clearing read while pend=4'h1. Required response: the next sel 2 read returns 32'h2.
6. **Release and mid-operation reset.**
   - Releasing a held button updates sel 1 to 0 after 5 cycles, with no pend change.
   - Asserting i_rst with cnt=2 and then releasing it requires a full 4 fresh stable samples before stable changes.
